// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the frame-sync ping-pong writer.
package frame_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT0,
        HUNT1,
        FILL,
        WAIT_BANK
    } state_t;

    localparam logic [15:0] DEF_SYNC0 = 16'hEB90;
    localparam logic [15:0] DEF_SYNC1 = 16'hFAF3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/frame_sync_pingpong_writer_bank.sv
// Two-bank bookkeeping: active bank pointer, per-bank full flags, busy checks.
module frame_bank_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       done_i,
    input  logic [1:0] release_i,
    output logic       bank_o,
    output logic [1:0] full_o,
    output logic       cur_busy_o,
    output logic       next_busy_o
);
    logic       bank_q, bank_d;
    logic [1:0] full_q, full_d;

    always_comb begin
        bank_d = bank_q;
        full_d = full_q & ~release_i;
        if (clear_i) begin
            bank_d = 1'b0;
            full_d = 2'b00;
        end else if (done_i) begin
            full_d[bank_q] = 1'b1;
            bank_d         = ~bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= 1'b0;
            full_q <= 2'b00;
        end else begin
            bank_q <= bank_d;
            full_q <= full_d;
        end
    end

    assign bank_o      = bank_q;
    assign full_o      = full_q;
    assign cur_busy_o  = full_q[bank_q];
    assign next_busy_o = full_q[~bank_q];

endmodule

// File: rtl/frame_sync_pingpong_writer.sv
// Hunts a two-word sync header in a FIFO stream and writes fixed-length
// frames alternately into two RAM banks, with stall timeout and error count.
module frame_sync_pingpong_writer
    import frame_sync_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                FRAME_LEN = 512,
    parameter int                ADDR_W    = 9,
    parameter logic [DATA_W-1:0] SYNC0     = DEF_SYNC0,
    parameter logic [DATA_W-1:0] SYNC1     = DEF_SYNC1,
    parameter int                TIMEOUT   = 1024,
    parameter int                ERR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update_flag,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] wr_dat,
    output logic [ADDR_W:0]   wr_addr,
    output logic              wr_en,
    output logic [1:0]        bank_full,
    input  logic [1:0]        bank_release,
    output logic              frame_done,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int              SIL_W    = clog2(TIMEOUT + 1);
    localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  REQ_MAX = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic               upd_q, rd_vld_q;
    logic [ADDR_W:0]    req_cnt_q, req_cnt_d;
    logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [SIL_W-1:0]   sil_q, sil_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               wr_en_q, done_q;
    logic [DATA_W-1:0]  wr_dat_q;
    logic [ADDR_W:0]    wr_addr_q;
    logic               want, err_inc, wr_fire, frame_end;
    logic               bank, cur_busy, next_busy;

    frame_bank_ctrl u_bank (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (update_flag),
        .done_i      (frame_end),
        .release_i   (bank_release),
        .bank_o      (bank),
        .full_o      (bank_full),
        .cur_busy_o  (cur_busy),
        .next_busy_o (next_busy)
    );

    assign want = (state_q == HUNT0) || (state_q == HUNT1) ||
                  ((state_q == FILL) && (req_cnt_q < REQ_MAX));
    assign fifo_rdreq = want && !fifo_empty && !update_flag;

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        sil_d     = sil_q;
        err_inc   = 1'b0;
        wr_fire   = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE:  if (upd_q && !update_flag) state_d = HUNT0;
            HUNT0: if (rd_vld_q && dat_in == SYNC0) state_d = HUNT1;
            HUNT1: begin
                if (rd_vld_q && dat_in == SYNC1) begin
                    // The request issued alongside the header word is already payload.
                    state_d   = FILL;
                    req_cnt_d = {ADDR_W'(0), fifo_rdreq};
                    wr_cnt_d  = '0;
                    sil_d     = '0;
                end else if (rd_vld_q && dat_in != SYNC0) begin
                    state_d = HUNT0;
                    err_inc = 1'b1;
                end
            end
            FILL: begin
                if (fifo_rdreq) req_cnt_d = req_cnt_q + 1'b1;
                if (rd_vld_q) begin
                    wr_fire  = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    sil_d    = '0;
                    if (wr_cnt_q == LAST_OFF) begin
                        frame_end = 1'b1;
                        state_d   = next_busy ? WAIT_BANK : HUNT0;
                    end
                end else if (sil_q == SIL_MAX) begin
                    state_d = HUNT0;
                    err_inc = 1'b1;
                    sil_d   = '0;
                end else begin
                    sil_d = sil_q + 1'b1;
                end
            end
            WAIT_BANK: if (!cur_busy) state_d = HUNT0;
            default:   state_d = IDLE;
        endcase
        if (update_flag) begin
            state_d   = IDLE;
            err_inc   = 1'b0;
            wr_fire   = 1'b0;
            frame_end = 1'b0;
        end
    end

    assign err_d = (err_inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            upd_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            req_cnt_q <= '0;
            wr_cnt_q  <= '0;
            sil_q     <= '0;
            err_q     <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_dat_q  <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            upd_q     <= update_flag;
            rd_vld_q  <= fifo_rdreq;
            req_cnt_q <= req_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            sil_q     <= sil_d;
            err_q     <= err_d;
            wr_en_q   <= wr_fire;
            done_q    <= frame_end;
            if (wr_fire) begin
                wr_dat_q  <= dat_in;
                wr_addr_q <= {bank, wr_cnt_q};
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_dat     = wr_dat_q;
    assign wr_addr    = wr_addr_q;
    assign frame_done = done_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_frame_sync_pingpong_writer.sv
// Bench for frame_sync_pingpong_writer: header-parse table, directed
// multi-cycle sequences, and a randomized stream against a word-level parser.
module tb_frame_sync_pingpong_writer;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int N  = 512;
    localparam int EW = 16;
    localparam logic [15:0] S0 = 16'hEB90;
    localparam logic [15:0] S1 = 16'hFAF3;

    logic          clk = 1'b0;
    logic          reset, update_flag, fifo_empty, fifo_rdreq;
    logic [DW-1:0] dat_in, wr_dat;
    logic [AW:0]   wr_addr;
    logic          wr_en, frame_done;
    logic [1:0]    bank_full, bank_release;
    logic [EW-1:0] err_cnt;

    frame_sync_pingpong_writer dut (
        .clk          (clk),
        .reset        (reset),
        .update_flag  (update_flag),
        .fifo_empty   (fifo_empty),
        .fifo_rdreq   (fifo_rdreq),
        .dat_in       (dat_in),
        .wr_dat       (wr_dat),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .frame_done   (frame_done),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW:0]   addr;
        logic [DW-1:0] dat;
        logic          done;
    } wr_t;

    typedef struct packed {
        logic [4:0][15:0] w;
        logic [2:0]       n;
        logic [1:0]       err_inc;
        logic             exp_wr;
    } vec_t;

    wr_t           wlog[$];
    wr_t           exp_q[$];
    logic [DW-1:0] fq[$];
    vec_t          tbl[6];
    int            checks = 0;
    int            failures = 0;
    int            err_exp = 0;
    bit            stall = 1'b0;
    bit            auto_rel = 1'b0;
    logic [1:0]    rel_req = 2'b00;
    int            rel_dly[2] = '{-1, -1};
    bit            m_hunt, m_in, m_bank;
    int            m_off, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic rq;
        @(negedge clk);
        fifo_empty   = stall || (fq.size() == 0);
        bank_release = rel_req;
        rel_req      = 2'b00;
        if (auto_rel) begin
            for (int b = 0; b < 2; b++) begin
                if (!bank_full[b]) rel_dly[b] = -1;
                else if (rel_dly[b] < 0) rel_dly[b] = int'($urandom_range(0, 600));
                else if (rel_dly[b] == 0) bank_release[b] = 1'b1;
                else rel_dly[b]--;
            end
        end
        #1;
        rq = fifo_rdreq;
        @(posedge clk);
        #1;
        if (rq && fq.size() > 0) dat_in = fq.pop_front();
        else dat_in = 16'($urandom);
        if (wr_en) wlog.push_back('{wr_addr, wr_dat, frame_done});
        if (frame_done) chk("done_with_wr", {31'd0, wr_en}, 1);
    endtask

    function automatic logic [15:0] pay(input int seed, input int i);
        return 16'(seed * 7919 + i * 3);
    endfunction

    function automatic vec_t mk(input int n, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d,
                                input int err, input bit wr);
        vec_t v;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = 16'h0;
        v.n = 3'(n); v.err_inc = 2'(err); v.exp_wr = wr;
        return v;
    endfunction

    task automatic push_hdr();
        fq.push_back(S0);
        fq.push_back(S1);
    endtask

    task automatic push_payload(input int seed, input int from, input int to);
        for (int i = from; i < to; i++) fq.push_back(pay(seed, i));
    endtask

    task automatic upd_pulse();
        update_flag = 1'b1;
        tick(); tick();
        fq.delete();
        update_flag = 1'b0;
        tick(); tick();
        wlog.delete();
    endtask

    task automatic run_writes(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, {31'd0, wlog.size() >= n}, 1);
    endtask

    task automatic chk_frame(input string name, input int start, input logic bank, input int seed);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            wr_t e;
            e = '{{bank, AW'(i)}, pay(seed, i), (i == N - 1)};
            if (start + i >= wlog.size()) bad++;
            else if (wlog[start + i] !== e) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Word-level parser of the consumed stream: sync hunt with overlap, then FRAME_LEN payload words.
    task automatic model_word(input logic [15:0] w);
        fq.push_back(w);
        if (m_in) begin
            exp_q.push_back('{{m_bank, AW'(m_off)}, w, (m_off == N - 1)});
            m_off++;
            if (m_off == N) begin
                m_in   = 1'b0;
                m_bank = ~m_bank;
            end
        end else if (!m_hunt) begin
            if (w == S0) m_hunt = 1'b1;
        end else if (w == S1) begin
            m_in = 1'b1; m_off = 0; m_hunt = 1'b0;
        end else if (w != S0) begin
            m_hunt = 1'b0;
            m_err++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, nw;
        logic [15:0] w;
        reset = 1'b1; update_flag = 1'b1; fifo_empty = 1'b1; dat_in = '0; bank_release = 2'b00;
        repeat (3) tick();
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_wr_addr", {22'd0, wr_addr}, 0);
        chk("rst_wr_dat", {16'd0, wr_dat}, 0);
        chk("rst_bank_full", {30'd0, bank_full}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 0);
        chk("rst_fifo_rdreq", {31'd0, fifo_rdreq}, 0);
        reset = 1'b0;

        tbl[0] = mk(2, S0, S1, 16'h0, 16'h0, 0, 1'b1);
        tbl[1] = mk(4, 16'h1234, S0, S0, S1, 0, 1'b1);
        tbl[2] = mk(2, S0, 16'h0000, 16'h0, 16'h0, 1, 1'b0);
        tbl[3] = mk(4, S0, 16'h0000, S0, S1, 1, 1'b1);
        tbl[4] = mk(3, S1, S0, S1, 16'h0, 0, 1'b1);
        tbl[5] = mk(3, S0, 16'h1234, S1, 16'h0, 1, 1'b0);
        foreach (tbl[i]) begin
            upd_pulse();
            for (int k = 0; k < int'(tbl[i].n); k++) fq.push_back(tbl[i].w[k]);
            fq.push_back(16'h5A5A);
            repeat (12) tick();
            err_exp += int'(tbl[i].err_inc);
            chk($sformatf("vec%0d_err", i), {16'd0, err_cnt}, err_exp);
            chk($sformatf("vec%0d_nwr", i), wlog.size(), {31'd0, tbl[i].exp_wr});
            if (tbl[i].exp_wr && wlog.size() > 0) begin
                chk($sformatf("vec%0d_addr", i), {22'd0, wlog[0].addr}, 0);
                chk($sformatf("vec%0d_dat", i), {16'd0, wlog[0].dat}, 32'h5A5A);
            end
        end

        // Two back-to-back frames fill both banks; third header must wait for a release.
        upd_pulse();
        push_hdr(); push_payload(1, 0, N);
        push_hdr(); push_payload(2, 0, N);
        push_hdr(); push_payload(3, 0, N);
        run_writes("f1_count", N, 3000);
        chk("f1_bank_full", {30'd0, bank_full}, 2'b01);
        run_writes("f2_count", 2 * N, 3000);
        chk("f2_bank_full", {30'd0, bank_full}, 2'b11);
        chk_frame("f1_data", 0, 1'b0, 1);
        chk_frame("f2_data", N, 1'b1, 2);
        repeat (20) tick();
        chk("wait_rdreq", {31'd0, fifo_rdreq}, 0);
        chk("wait_nowr", wlog.size(), 2 * N);
        chk("wait_fifo_left", fq.size(), N + 2);
        rel_req = 2'b01;
        tick();
        chk("rel_bank_full", {30'd0, bank_full}, 2'b10);
        run_writes("f3_count", 3 * N, 3000);
        chk_frame("f3_data", 2 * N, 1'b0, 3);

        // Short mid-frame stall resumes seamlessly.
        upd_pulse();
        push_hdr(); push_payload(4, 0, 200);
        run_writes("st_pre", 200, 1000);
        repeat (100) tick();
        chk("st_mid_nwr", wlog.size(), 200);
        push_payload(4, 200, N);
        run_writes("st_post", N, 2000);
        chk_frame("st_data", 0, 1'b0, 4);
        chk("st_err", {16'd0, err_cnt}, err_exp);

        // Long stall aborts the partial frame in bank 1; next frame restarts there.
        wlog.delete();
        push_hdr(); push_payload(5, 0, 300);
        run_writes("to_pre", 300, 1000);
        repeat (1010) tick();
        chk("to_err_before", {16'd0, err_cnt}, err_exp);
        repeat (30) tick();
        err_exp++;
        chk("to_err_after", {16'd0, err_cnt}, err_exp);
        chk("to_bank_full", {30'd0, bank_full}, 2'b01);
        wlog.delete();
        push_hdr(); push_payload(6, 0, N);
        run_writes("to_next", N, 2000);
        chk_frame("to_restart", 0, 1'b1, 6);
        chk("to_bank_full2", {30'd0, bank_full}, 2'b11);

        // update_flag mid-frame.
        rel_req = 2'b01;
        tick();
        wlog.delete();
        push_hdr(); push_payload(7, 0, N);
        run_writes("up_pre", 300, 1000);
        update_flag = 1'b1;
        repeat (5) tick();
        chk("up_wr_stop", {31'd0, wlog.size() <= 301}, 1);
        chk("up_bank_full", {30'd0, bank_full}, 2'b00);
        chk("up_rdreq", {31'd0, fifo_rdreq}, 0);
        chk("up_err_kept", {16'd0, err_cnt}, err_exp);
        fq.delete();
        update_flag = 1'b0;
        repeat (2) tick();
        wlog.delete();
        push_hdr(); push_payload(8, 0, N);
        run_writes("up_next", N, 2000);
        chk_frame("up_restart", 0, 1'b0, 8);
        chk("up_bank_full2", {30'd0, bank_full}, 2'b01);

        // Randomized stream with stalls and random consumer release delays.
        upd_pulse();
        auto_rel = 1'b1;
        exp_q.delete();
        m_hunt = 1'b0; m_in = 1'b0; m_bank = 1'b0; m_off = 0; m_err = 0;
        for (int f = 0; f < 4; f++) begin
            nw = int'($urandom_range(0, 3));
            for (int k = 0; k < nw; k++) begin
                case ($urandom_range(0, 3))
                    0: w = 16'($urandom);
                    1: w = S0;
                    2: w = S1;
                    default: w = 16'h0000;
                endcase
                model_word(w);
            end
            model_word(S0);
            model_word(S1);
            for (int k = 0; k < N; k++) model_word(16'($urandom));
        end
        nw = 0;
        while (fq.size() > 0 && nw < 30000) begin
            if ($urandom_range(0, 99) == 0) begin
                stall = 1'b1;
                repeat (50) tick();
                nw += 50;
            end
            stall = ($urandom_range(0, 7) == 0);
            tick();
            nw++;
        end
        stall = 1'b0;
        chk("rnd_drain", fq.size(), 0);
        repeat (300) tick();
        chk("rnd_nwr", wlog.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= wlog.size()) bad++;
            else if (wlog[i] !== exp_q[i]) bad++;
        end
        chk("rnd_data", bad, 0);
        chk("rnd_err", {16'd0, err_cnt}, err_exp + m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sync_pingpong_writer.md
Name: frame_sync_pingpong_writer

Overview:
Successor to the single-buffer sync-and-store writer. Reads a word stream from an upstream FIFO, hunts for a two-word sync header, then writes a fixed-length frame payload into one half of a two-bank RAM. Ping-pong banking lets a downstream consumer drain one bank while the other fills. Adds mid-frame stall tolerance, a stall timeout, and a saturating error counter.

Parameters:
DATA_W, 16, data and sync word width
FRAME_LEN, 512, payload words per frame (power of two, 2..2^ADDR_W)
ADDR_W, 9, per-bank address width; log2(FRAME_LEN)
SYNC0, 16'hEB90, first sync word
SYNC1, 16'hFAF3, second sync word
TIMEOUT, 1024, idle cycles tolerated mid-frame before abort
ERR_W, 16, error counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
update_flag  in  1  level; high = abort and hold; high->low arms hunting
fifo_empty  in  1  upstream FIFO empty
fifo_rdreq  out  1  FIFO read request; data valid one cycle later
dat_in  in  DATA_W  FIFO read data
wr_dat  out  DATA_W  RAM write data
wr_addr  out  ADDR_W+1  RAM write address {bank, offset}
wr_en  out  1  RAM write strobe
bank_full  out  2  per-bank "frame ready" flags
bank_release  in  2  consumer pulse; clears matching bank_full
frame_done  out  1  one-cycle pulse when a bank completes
err_cnt  out  ERR_W  saturating count of sync losses plus timeouts

Behaviour:
- Reset values: all outputs 0; state IDLE; bank pointer 0; internal counters 0.
- rd_vld = fifo_rdreq delayed by one cycle. dat_in is consumed only when rd_vld=1.
- fifo_rdreq = !fifo_empty && want. want is 1 in HUNT0/HUNT1 and in FILL while req_cnt < FRAME_LEN; 0 otherwise.
- State machine:
  - IDLE: leave on the cycle after update_flag falls; go to HUNT0.
  - HUNT0: rd_vld && dat_in==SYNC0 -> HUNT1; any other word stays in HUNT0 with no error.
  - HUNT1: rd_vld && dat_in==SYNC1 -> FILL. dat_in==SYNC0 stays in HUNT1 (overlap). Any other word -> HUNT0 and err_cnt+1.
  - On entry to FILL: req_cnt loads 1 if fifo_rdreq was high in the entry cycle, else 0; wr_cnt loads 0.
  - FILL: each rd_vld writes dat_in at {bank, wr_cnt} and wr_cnt increments. req_cnt increments on each fifo_rdreq.
  - FILL completion: on the write with wr_cnt==FRAME_LEN-1, set bank_full[bank], pulse frame_done, and toggle bank. Then go to HUNT0 if bank_full[new bank]==0, else WAIT_BANK.
  - WAIT_BANK: no reads; when bank_full[bank] clears, go to HUNT0 on the next cycle.
- Write port is registered: wr_dat/wr_addr/wr_en follow the rd_vld cycle by one clock. frame_done is coincident with the last wr_en.
- Stall: FIFO empty mid-FILL pauses the frame; it is not an error.
- Timeout: a silence counter increments in FILL on every cycle without rd_vld and clears on rd_vld. When it reaches TIMEOUT, the partial frame is abandoned: bank_full unchanged, bank pointer unchanged, err_cnt+1, go to HUNT0. The next frame overwrites from offset 0.
- err_cnt saturates at all-ones and is cleared only by reset.
- bank_release[b] clears bank_full[b] the next cycle. Release of an empty bank is ignored. Release and set cannot coincide on one bank by construction.
- update_flag high (any state, priority over everything but reset):
  - next state IDLE; fifo_rdreq 0; clear bank_full and bank pointer; err_cnt kept.
  - An in-flight rd_vld word is discarded; no wr_en for it.
- Address width: offset is ADDR_W bits, wraps naturally. wr_addr MSB is the bank bit.

Decomposition:
- Package frame_sync_pkg: state encoding (IDLE, HUNT0, HUNT1, FILL, WAIT_BANK), default sync constants, clog2 helper.
- One sub-module, frame_bank_ctrl: bank pointer, bank_full set/release, and the free-bank check driving WAIT_BANK.

Test Plan:
- update_flag 1->0, FIFO supplies EB90, FAF3, 0..511 -> 512 writes; wr_addr 0x000..0x1FF; bank_full=01; frame_done with last write.
- Second frame back-to-back, no release -> writes 0x200..0x3FF, bank_full=11. Third header arrives -> WAIT_BANK, fifo_rdreq 0. Pulse bank_release=01 -> third frame writes 0x000.
- Stream 1234, EB90, EB90, FAF3, payload -> aligns; err_cnt stays 0. Stream EB90, 0000 -> err_cnt=1, back in HUNT0.
- FIFO empty for 100 cycles at word 200 (TIMEOUT=1024) -> resumes; wr_addr continues at 200; no error.
- FIFO empty 1024 cycles mid-frame -> err_cnt+1, bank_full unchanged; next frame restarts at offset 0 of the same bank.
- update_flag pulsed at word 300 -> wr_en stops within one cycle; bank_full=00. After update_flag falls, a new frame writes bank 0 from 0x000.
